lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker_pkg.sv | 26 ++
 rtl/lfsr_sat_cnt.sv | 34 +++
 rtl/lfsr_checker.sv | 157 +++++++++++++++
 tb/tb_lfsr_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 24-bit noise-generator LFSR checker:
// feedback taps, the one-step prediction function, FSM states and lock defaults.
package lfsr_pkg;

    localparam int LFSR_W = 24;

    localparam int TAP_A = 23;
    localparam int TAP_B = 22;
    localparam int TAP_C = 20;
    localparam int TAP_D = 19;

    localparam int LOCK_CNT_DEF = 4;
    localparam int LOSS_CNT_DEF = 3;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Predicted next received word: one shift per word, feedback in the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
        return {w[LFSR_W-2:0], w[TAP_A] ^ w[TAP_B] ^ w[TAP_C] ^ w[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr_sat_cnt.sv
// Saturating up-counter; a clear on the same cycle as an increment wins.
module lfsr_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 24-bit noise LFSR: hunts, syncs, locks and flywheels
// through errors. Optional word counter enabled by defining LFSR_CHECK_STATS_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int LOSS_CNT = LOSS_CNT_DEF,
    parameter int ERR_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [LFSR_W-1:0] data,
    input  logic                    clr_cnt,
    output logic                    locked,
    output logic                    err_pulse,
    output logic [ERR_W-1:0]        err_count,
    output logic                    zero_seen
`ifdef LFSR_CHECK_STATS_EN
    ,
    output logic [31:0]             word_count
`endif
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] ref_q, ref_d;
    logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
    logic [MS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              zero_seen_q, zero_seen_d;

    logic [LFSR_W-1:0] data_u;
    logic [LFSR_W-1:0] pred;
    logic              is_zero;
    logic              is_match;
    logic              err_hit;

    assign data_u   = data;
    assign pred     = lfsr_next(ref_q);
    assign is_zero  = (data_u == '0);
    // The all-zero word is the LFSR lockup state, so it never counts as a match.
    assign is_match = !is_zero && (data_u == pred);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_hit     = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (!is_zero) begin
                        ref_d       = data_u;
                        match_cnt_d = '0;
                        state_d     = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    ref_d = data_u;
                    if (is_match) begin
                        if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            state_d     = ST_LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + MC_W'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_match) begin
                        ref_d      = data_u;
                        miss_cnt_d = '0;
                    end else begin
                        // Flywheel on the prediction so a corrupted word cannot derail the reference.
                        ref_d   = pred;
                        err_hit = 1'b1;
                        if (miss_cnt_q == MS_W'(LOSS_CNT - 1)) begin
                            miss_cnt_d = '0;
                            state_d    = ST_HUNT;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    assign err_pulse_d = err_hit;
    assign zero_seen_d = clr_cnt ? 1'b0 : (zero_seen_q | (in_valid & is_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            ref_q       <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    lfsr_sat_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk    (clk),
        .rst_ni (reset),
        .clr_i  (clr_cnt),
        .inc_i  (err_hit),
        .cnt_o  (err_count)
    );

`ifdef LFSR_CHECK_STATS_EN
    logic [31:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (clr_cnt) begin
            word_count_d = '0;
        end else if (in_valid) begin
            word_count_d = word_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`endif

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed table-driven bench for lfsr_checker plus hand sequences for
// saturation, clear-vs-error, and asynchronous reset while locked.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] data = 24'h0;
    logic        clr_cnt = 1'b0;

    logic        locked, err_pulse, zero_seen;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s, zero_seen_s;
    logic [3:0]  err_count_s;
`ifdef LFSR_CHECK_STATS_EN
    logic [31:0] word_count, word_count_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data      (data),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .zero_seen (zero_seen)
`ifdef LFSR_CHECK_STATS_EN
        ,
        .word_count (word_count)
`endif
    );

    // Narrow-counter instance sharing the stimulus, used to reach saturation quickly.
    lfsr_checker #(.ERR_W(4)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data      (data),
        .clr_cnt   (clr_cnt),
        .locked    (locked_s),
        .err_pulse (err_pulse_s),
        .err_count (err_count_s),
        .zero_seen (zero_seen_s)
`ifdef LFSR_CHECK_STATS_EN
        ,
        .word_count (word_count_s)
`endif
    );

    typedef struct {
        logic        valid;
        logic [23:0] data;
        logic        clr;
        logic        exp_locked;
        logic        exp_pulse;
        logic [15:0] exp_cnt;
        logic        exp_zero;
    } vec_t;

    vec_t vt[$];

    function automatic logic [23:0] tb_next(input logic [23:0] w);
        logic fb;
        fb = w[23] ^ w[22] ^ w[20] ^ w[19];
        return {w[22:0], fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called on a falling edge: drive one word, let the rising edge take it, return on the next falling edge.
    task automatic send(input logic v, input logic [23:0] d, input logic c);
        in_valid = v;
        data     = d;
        clr_cnt  = c;
        @(negedge clk);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic add(input logic v, input logic [23:0] d, input logic c,
                       input logic l, input logic p, input logic [15:0] n, input logic z);
        vec_t r;
        r.valid = v; r.data = d; r.clr = c;
        r.exp_locked = l; r.exp_pulse = p; r.exp_cnt = n; r.exp_zero = z;
        vt.push_back(r);
    endtask

    initial begin
        logic [23:0] ref_m;
        logic [23:0] w;
        int          errs;
        int          exp_s;

        //   valid data       clr   lock pulse cnt  zero
        add(1, 24'hC00000, 0,    0, 0, 0, 0);
        add(1, 24'h800000, 0,    0, 0, 0, 0);
        add(1, 24'h000001, 0,    0, 0, 0, 0);
        add(1, 24'h000002, 0,    0, 0, 0, 0);
        add(1, 24'h000004, 0,    1, 0, 0, 0);
        add(1, 24'h000008, 0,    1, 0, 0, 0);
        add(1, 24'h123456, 0,    1, 1, 1, 0);
        add(1, 24'h000020, 0,    1, 0, 1, 0);
        add(0, 24'hAAAAAA, 0,    1, 0, 1, 0);
        add(0, 24'h000000, 1,    1, 0, 0, 0);
        add(1, 24'h000040, 0,    1, 0, 0, 0);
        add(1, 24'h111111, 0,    1, 1, 1, 0);
        add(1, 24'h222222, 0,    1, 1, 2, 0);
        add(1, 24'h333333, 0,    0, 1, 3, 0);
        add(0, 24'h555555, 0,    0, 0, 3, 0);
        add(1, 24'h000000, 0,    0, 0, 3, 1);
        add(1, 24'h000100, 0,    0, 0, 3, 1);
        add(1, 24'h000200, 0,    0, 0, 3, 1);
        for (int k = 0; k < 5; k++) add(1, 24'h000000, 0, 0, 0, 3, 1);
        add(0, 24'h000000, 1,    0, 0, 0, 0);
        add(1, 24'h000001, 0,    0, 0, 0, 0);
        add(1, 24'h000002, 0,    0, 0, 0, 0);
        add(1, 24'h000004, 0,    0, 0, 0, 0);
        add(1, 24'h000008, 0,    0, 0, 0, 0);
        add(1, 24'h000010, 0,    1, 0, 0, 0);

        #1 reset = 1'b0;
        #1;
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("reset_err_count", {16'd0, err_count}, 32'd0);
        chk("reset_zero_seen", {31'd0, zero_seen}, 32'd0);
`ifdef LFSR_CHECK_STATS_EN
        chk("reset_word_count", word_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].valid, vt[i].data, vt[i].clr);
            $display("row %0d: valid=%0d data=0x%06h clr=%0d -> locked=%0d pulse=%0d cnt=%0d zero=%0d",
                     i, vt[i].valid, vt[i].data, vt[i].clr, locked, err_pulse, err_count, zero_seen);
            chk($sformatf("row%0d_locked", i), {31'd0, locked}, {31'd0, vt[i].exp_locked});
            chk($sformatf("row%0d_err_pulse", i), {31'd0, err_pulse}, {31'd0, vt[i].exp_pulse});
            chk($sformatf("row%0d_err_count", i), {16'd0, err_count}, {16'd0, vt[i].exp_cnt});
            chk($sformatf("row%0d_zero_seen", i), {31'd0, zero_seen}, {31'd0, vt[i].exp_zero});
        end

        // Sixteen errors while staying locked (bad, bad, good): narrow counter pins at 15.
        ref_m = 24'h000010;
        errs  = 0;
        for (int g = 0; g < 8; g++) begin
            for (int b = 0; b < 2; b++) begin
                w = tb_next(ref_m) ^ 24'h5A5A5A;
                send(1'b1, w, 1'b0);
                ref_m = tb_next(ref_m);
                errs++;
                exp_s = (errs > 15) ? 15 : errs;
                $display("err %0d: data=0x%06h cnt=%0d cnt_s=%0d locked=%0d", errs, w, err_count, err_count_s, locked);
                chk($sformatf("sat_pulse_%0d", errs), {31'd0, err_pulse}, 32'd1);
                chk($sformatf("sat_cnt_%0d", errs), {16'd0, err_count}, errs);
                chk($sformatf("sat_cnt_s_%0d", errs), {28'd0, err_count_s}, exp_s);
            end
            ref_m = tb_next(ref_m);
            send(1'b1, ref_m, 1'b0);
            chk($sformatf("sat_locked_%0d", g), {31'd0, locked}, 32'd1);
        end

        // Clear coincident with an error: counters go to zero but the pulse still fires.
        w = tb_next(ref_m) ^ 24'h0F0F0F;
        send(1'b1, w, 1'b1);
        ref_m = tb_next(ref_m);
        $display("clr+err: pulse=%0d cnt=%0d cnt_s=%0d locked=%0d", err_pulse, err_count, err_count_s, locked);
        chk("clr_err_pulse", {31'd0, err_pulse}, 32'd1);
        chk("clr_err_count", {16'd0, err_count}, 32'd0);
        chk("clr_err_count_s", {28'd0, err_count_s}, 32'd0);
        chk("clr_err_locked", {31'd0, locked}, 32'd1);

        ref_m = tb_next(ref_m);
        send(1'b1, ref_m, 1'b0);
        w = tb_next(ref_m) ^ 24'h00FF00;
        send(1'b1, w, 1'b0);
        ref_m = tb_next(ref_m);
        chk("pre_reset_pulse", {31'd0, err_pulse}, 32'd1);
        chk("pre_reset_count", {16'd0, err_count}, 32'd1);
        chk("pre_reset_locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset between edges must clear outputs before the next rising edge.
        #2 reset = 1'b0;
        #1;
        $display("async reset: locked=%0d pulse=%0d cnt=%0d zero=%0d", locked, err_pulse, err_count, zero_seen);
        chk("async_locked", {31'd0, locked}, 32'd0);
        chk("async_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("async_err_count", {16'd0, err_count}, 32'd0);
        chk("async_err_count_s", {28'd0, err_count_s}, 32'd0);
        chk("async_zero_seen", {31'd0, zero_seen}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Lock is gone after release; a fresh HUNT word plus four matches relocks.
        w = tb_next(ref_m);
        for (int k = 0; k < 5; k++) begin
            send(1'b1, w, 1'b0);
            $display("resync %0d: data=0x%06h locked=%0d", k, w, locked);
            chk($sformatf("resync_locked_%0d", k), {31'd0, locked}, (k == 4) ? 32'd1 : 32'd0);
            w = tb_next(w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
